// File: rtl/div_issue_ctrl.sv
// Issue controller for a fixed-latency signed 8-bit divider: registers operands,
// tracks in-flight requests with a tag pipeline and buffers results in a credit-guarded FWFT FIFO.
module div_issue_ctrl #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_dividend,
    input  logic [7:0] req_divisor,
    output logic [7:0] dividend,
    output logic [7:0] divisor,
    input  logic [7:0] quotient,
    input  logic [7:0] reminder,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_quotient,
    output logic [7:0] rsp_reminder,
    output logic       rsp_dz
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [LAT-1:0] r_tag_valid;
    logic [LAT-1:0] r_tag_dz;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_occ;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [16:0]    r_mem [DEPTH];

    logic        w_accept;
    logic        w_pop;
    logic        w_push;
    logic [16:0] w_push_data;
    logic [16:0] w_head;

    // Credits cover both in-flight tags and stored entries, so a push always finds room.
    assign req_ready   = (r_count < DEPTH_C);
    assign w_accept    = req_valid && req_ready;
    assign rsp_valid   = (r_occ != '0);
    assign w_pop       = rsp_valid && rsp_ready;
    assign w_push      = r_tag_valid[LAT-1];
    assign w_push_data = r_tag_dz[LAT-1] ? {16'h0000, 1'b1} : {quotient, reminder, 1'b0};
    assign w_head      = r_mem[r_rd_ptr];

    assign rsp_quotient = rsp_valid ? w_head[16:9] : 8'h00;
    assign rsp_reminder = rsp_valid ? w_head[8:1]  : 8'h00;
    assign rsp_dz       = rsp_valid ? w_head[0]    : 1'b0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dividend    <= 8'h00;
            divisor     <= 8'h00;
            r_tag_valid <= '0;
            r_tag_dz    <= '0;
        end else begin
            if (w_accept) begin
                dividend <= req_dividend;
                divisor  <= req_divisor;
            end
            r_tag_valid[0] <= w_accept;
            r_tag_dz[0]    <= w_accept && (req_divisor == 8'h00);
            for (int i = 1; i < LAT; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_dz[i]    <= r_tag_dz[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_occ    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + CW'(1);
                2'b01:   r_occ <= r_occ - CW'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

endmodule
